// File: rtl/gpu_isa_pkg.sv
// Opcodes, instruction field positions and decode helpers shared by the
// instruction controller and the memory-side data cache controller.
package gpu_isa_pkg;

    typedef enum logic [3:0] {
        OP_NOP    = 4'b0000,
        OP_SMA    = 4'b0110,
        OP_LOADI  = 4'b0111,
        OP_SENDL  = 4'b1000,
        OP_LOADB  = 4'b1001,
        OP_WRITEB = 4'b1010
    } opcode_e;

    // Field bounds use MSB-first numbering: instruction bit 0 is the MSB.
    localparam int OP_FIRST    = 0;
    localparam int OP_LAST     = 3;
    localparam int REG_A_FIRST = 4;
    localparam int REG_A_LAST  = 7;
    localparam int IMM_FIRST   = 8;
    localparam int IMM_LAST    = 23;
    localparam int REG_B_FIRST = 24;
    localparam int REG_B_LAST  = 27;

    typedef struct packed {
        logic valid;
        logic replace_c;
        logic fma_valid;
    } sideband_t;

    function automatic logic is_mem_op(input logic [3:0] op);
        logic hit;
        hit = 1'b0;
        case (op)
            OP_SMA, OP_LOADI, OP_SENDL, OP_LOADB, OP_WRITEB: hit = 1'b1;
            default:                                         hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/data_cache.sv
// Data cache storage: true-dual-port read-first BRAM with port A write-only
// and port B read-only, plus the registered (high-performance) read output.
module data_cache
#(
    parameter int WIDTH      = 144,
    parameter int DEPTH      = 4096,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
)
(
    input  logic                  clk_a,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  clk_b,
    input  logic                  rst_b,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] ram_q;

    always_ff @(posedge clk_a) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk_b) begin
        if (rd_en) begin
            ram_q <= mem[rd_addr];
        end
    end

    // Only the output register is resettable, matching the BRAM primitive.
    always_ff @(posedge clk_b) begin
        if (rst_b) begin
            rd_data <= '0;
        end else begin
            rd_data <= ram_q;
        end
    end

endmodule

// File: rtl/data_cache_controller.sv
// Executes SMA/LOADI/SENDL/WRITEB against a working line buffer and the data
// cache, streaming WRITEB lines to the FMA array three cycles after the strobe.
module data_cache_controller
    import gpu_isa_pkg::*;
#(
    parameter int    INSTRUCTION_WIDTH = 32,
    parameter int    DATA_CACHE_WIDTH  = 16,
    parameter int    DATA_CACHE_DEPTH  = 4096,
    parameter int    WORDS_PER_LINE    = 9,
    parameter string INIT_FILE         = ""
)
(
    input  logic                                     clk_in,
    input  logic                                     rst_in,
    input  logic [0:INSTRUCTION_WIDTH-1]             instr_in,
    input  logic                                     instr_valid_in,
    output logic [WORDS_PER_LINE*DATA_CACHE_WIDTH-1:0] line_out,
    output logic                                     replace_c_out,
    output logic                                     fma_valid_out,
    output logic                                     line_valid_out,
    output logic [$clog2(DATA_CACHE_DEPTH)-1:0]      addr_out
);

    localparam int ADDR_W = $clog2(DATA_CACHE_DEPTH);
    localparam int LINE_W = WORDS_PER_LINE * DATA_CACHE_WIDTH;
    localparam bit unused_init = (INIT_FILE != "");

    // Handshake: instr_valid_in is a fire-and-forget strobe with no ready;
    // every high cycle consumes exactly one instruction, and line_valid_out is
    // likewise a one-cycle strobe per line with no backpressure from the FMAs.

    logic [3:0]  op;
    logic [3:0]  reg_a;
    logic [15:0] imm;
    logic        mem_strobe;
    logic        do_sma;
    logic        do_loadi;
    logic        do_sendl;
    logic        do_writeb;
    logic        unused_instr;

    assign op         = instr_in[OP_FIRST:OP_LAST];
    assign reg_a      = instr_in[REG_A_FIRST:REG_A_LAST];
    assign imm        = instr_in[IMM_FIRST:IMM_LAST];
    assign mem_strobe = instr_valid_in && is_mem_op(op);
    assign do_sma     = mem_strobe && (op == OP_SMA);
    assign do_loadi   = mem_strobe && (op == OP_LOADI);
    assign do_sendl   = mem_strobe && (op == OP_SENDL);
    assign do_writeb  = mem_strobe && (op == OP_WRITEB);
    assign unused_instr = ^{instr_in[REG_B_FIRST:REG_B_LAST-1],
                            instr_in[REG_B_LAST+1:INSTRUCTION_WIDTH-1]};

    logic [ADDR_W-1:0]           addr;
    logic [DATA_CACHE_WIDTH-1:0] line_buf [WORDS_PER_LINE];
    logic [LINE_W-1:0]           buf_packed;
    logic [ADDR_W-1:0]           rd_addr;
    logic [LINE_W-1:0]           rd_data;
    sideband_t                   sb [3];
    logic [1:0]                  rst_pipe;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            addr <= '0;
            for (int k = 0; k < WORDS_PER_LINE; k++) begin
                line_buf[k] <= '0;
            end
        end else begin
            if (do_sma) begin
                addr <= ADDR_W'(imm);
            end
            // Out-of-range word indices match no slot and are dropped.
            for (int k = 0; k < WORDS_PER_LINE; k++) begin
                if (do_loadi && (reg_a == 4'(k))) begin
                    line_buf[k] <= DATA_CACHE_WIDTH'(imm);
                end
            end
        end
    end

    always_comb begin
        buf_packed = '0;
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            buf_packed[k*DATA_CACHE_WIDTH +: DATA_CACHE_WIDTH] = line_buf[k];
        end
    end

    // Sideband stage 0 also holds the read address, so the BRAM read and its
    // output register line up with stages 1 and 2.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int s = 0; s < 3; s++) begin
                sb[s] <= '0;
            end
            rd_addr <= '0;
        end else begin
            sb[0] <= '{valid:     do_writeb,
                       replace_c: instr_in[REG_A_LAST],
                       fma_valid: instr_in[REG_B_LAST]};
            sb[1] <= sb[0];
            sb[2] <= sb[1];
            if (do_writeb) begin
                rd_addr <= ADDR_W'(imm);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            line_out       <= '0;
            replace_c_out  <= 1'b0;
            fma_valid_out  <= 1'b0;
            line_valid_out <= 1'b0;
        end else begin
            line_valid_out <= sb[2].valid;
            if (sb[2].valid) begin
                line_out      <= rd_data;
                replace_c_out <= sb[2].replace_c;
                fma_valid_out <= sb[2].fma_valid;
            end
        end
    end

    // The BRAM output register takes a synchronous, active-high reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rst_pipe <= 2'b11;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b0};
        end
    end

    data_cache #(
        .WIDTH (LINE_W),
        .DEPTH (DATA_CACHE_DEPTH)
    ) u_data_cache (
        .clk_a   (clk_in),
        .wr_en   (do_sendl),
        .wr_addr (addr),
        .wr_data (buf_packed),
        .clk_b   (clk_in),
        .rst_b   (rst_pipe[1]),
        .rd_en   (sb[0].valid),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign addr_out = addr;

endmodule

// File: tb/tb_data_cache_controller.sv
// Bench for data_cache_controller: directed scenarios plus random traffic,
// checked against an opcode-level model of the line buffer and cache.
module tb_data_cache_controller;

    localparam int IW  = 32;
    localparam int W   = 16;
    localparam int DEP = 4096;
    localparam int WPL = 9;
    localparam int LW  = WPL * W;
    localparam int AW  = 12;

    localparam logic [3:0] C_NOP    = 4'b0000;
    localparam logic [3:0] C_ADDI   = 4'b0001;
    localparam logic [3:0] C_SMA    = 4'b0110;
    localparam logic [3:0] C_LOADI  = 4'b0111;
    localparam logic [3:0] C_SENDL  = 4'b1000;
    localparam logic [3:0] C_LOADB  = 4'b1001;
    localparam logic [3:0] C_WRITEB = 4'b1010;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] instr = '0;
    logic          instr_valid = 1'b0;
    logic [LW-1:0] line_out;
    logic          replace_c;
    logic          fma_valid;
    logic          line_valid;
    logic [AW-1:0] addr_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic mon_en = 1'b0;
    logic exp_v;

    logic [W-1:0]    m_buf [WPL];
    logic [AW-1:0]   m_addr;
    logic [LW-1:0]   m_cache [int];
    logic [LW+1:0]   exp_q [$];
    int              due_q [$];

    data_cache_controller #(
        .INSTRUCTION_WIDTH (IW),
        .DATA_CACHE_WIDTH  (W),
        .DATA_CACHE_DEPTH  (DEP),
        .WORDS_PER_LINE    (WPL),
        .INIT_FILE         ("")
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .instr_in       (instr),
        .instr_valid_in (instr_valid),
        .line_out       (line_out),
        .replace_c_out  (replace_c),
        .fma_valid_out  (fma_valid),
        .line_valid_out (line_valid),
        .addr_out       (addr_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [LW-1:0] pack_buf();
        logic [LW-1:0] v;
        for (int k = 0; k < WPL; k++) v[k*W +: W] = m_buf[k];
        return v;
    endfunction

    task automatic model_reset();
        m_addr = '0;
        for (int k = 0; k < WPL; k++) m_buf[k] = '0;
        exp_q.delete();
        due_q.delete();
    endtask

    task automatic model_step(input logic [3:0] op, input logic [3:0] ra,
                              input logic [15:0] imm, input logic [3:0] rb, input int n);
        logic [LW-1:0] data;
        case (op)
            C_SMA:   m_addr = imm[AW-1:0];
            C_LOADI: if (ra < WPL) m_buf[ra] = imm;
            C_SENDL: m_cache[int'(m_addr)] = pack_buf();
            C_WRITEB: begin
                data = m_cache.exists(int'(imm[AW-1:0])) ? m_cache[int'(imm[AW-1:0])] : '0;
                exp_q.push_back({ra[0], rb[0], data});
                due_q.push_back(n + 3);
            end
            default: ;
        endcase
    endtask

    // ---------------- driver ----------------
    task automatic issue(input logic [3:0] op, input logic [3:0] ra, input logic [15:0] imm,
                         input logic [3:0] rb, input logic v, output int n);
        @(negedge clk);
        instr = {op, ra, imm, rb, 4'h0};
        instr_valid = v;
        n = cyc + 1;
        @(posedge clk);
        if (v) model_step(op, ra, imm, rb, n);
        #1 instr_valid = 1'b0;
    endtask

    task automatic get_strobe(input int n, output int lat);
        lat = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (line_valid === 1'b1) begin
                lat = cyc - n;
                break;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
            checks++;
            if (line_valid !== exp_v) begin
                errors++;
                $display("FAIL sb_strobe cyc=%0d got=%b exp=%b", cyc, line_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if ({replace_c, fma_valid, line_out} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL sb_line cyc=%0d got=%h exp=%h", cyc,
                             {replace_c, fma_valid, line_out}, exp_q[0]);
                end
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
            checks++;
            if (addr_o !== m_addr) begin
                errors++;
                $display("FAIL sb_addr cyc=%0d got=%h exp=%h", cyc, addr_o, m_addr);
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        mon_en = 1'b0;
        rst_n = 1'b0;
        instr_valid = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({line_valid, replace_c, fma_valid, line_out, addr_o} !== '0) begin
            errors++;
            $display("FAIL reset_values got v=%b rc=%b fv=%b addr=%h line=%h exp all 0",
                     line_valid, replace_c, fma_valid, addr_o, line_out);
        end
        rst_n = 1'b1;
        mon_en = 1'b1;
        issue(C_SMA, 4'd0, 16'd3, 4'd0, 1'b1, n);
        issue(C_LOADI, 4'd0, 16'h0001, 4'd0, 1'b1, n);
        issue(C_SENDL, 4'd0, 16'd0, 4'd0, 1'b1, n);
        issue(C_WRITEB, 4'd1, 16'd3, 4'd1, 1'b1, n);
        @(negedge clk);
        #2 rst_n = 1'b0;
        mon_en = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({line_valid, replace_c, fma_valid, line_out, addr_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid_writeb got v=%b rc=%b fv=%b addr=%h exp all 0",
                     line_valid, replace_c, fma_valid, addr_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (line_valid !== 1'b0 || addr_o !== '0) begin
                errors++;
                $display("FAIL reset_dropped cyc=%0d v=%b addr=%h exp v=0 addr=0", cyc, line_valid, addr_o);
            end
        end
    endtask

    task automatic test_round_trip();
        int n, lat;
        logic [LW-1:0] e;
        e = '0;
        e[0 +: W] = 16'h1234;
        e[8*W +: W] = 16'hBEEF;
        issue(C_SMA, 4'd0, 16'd5, 4'd0, 1'b1, n);
        issue(C_LOADI, 4'd0, 16'h1234, 4'd0, 1'b1, n);
        issue(C_LOADI, 4'd8, 16'hBEEF, 4'd0, 1'b1, n);
        issue(C_SENDL, 4'd0, 16'd0, 4'd0, 1'b1, n);
        issue(C_WRITEB, 4'd1, 16'd5, 4'd1, 1'b1, n);
        get_strobe(n, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL rt_latency got=%0d exp=3", lat);
        end
        checks++;
        if (line_out !== e || replace_c !== 1'b1 || fma_valid !== 1'b1) begin
            errors++;
            $display("FAIL rt_line got=%h rc=%b fv=%b exp=%h rc=1 fv=1", line_out, replace_c, fma_valid, e);
        end
        @(negedge clk);
        checks++;
        if (line_valid !== 1'b0 || line_out !== e || replace_c !== 1'b1) begin
            errors++;
            $display("FAIL rt_hold got v=%b line=%h exp v=0 line=%h", line_valid, line_out, e);
        end
    endtask

    task automatic test_out_of_range();
        int n, lat;
        logic [LW-1:0] e;
        e = '0;
        e[0 +: W] = 16'h1234;
        e[8*W +: W] = 16'hBEEF;
        issue(C_LOADI, 4'd12, 16'hDEAD, 4'd0, 1'b1, n);
        issue(C_LOADI, 4'd9, 16'hCAFE, 4'd0, 1'b1, n);
        issue(C_SMA, 4'd0, 16'd9, 4'd0, 1'b1, n);
        issue(C_SENDL, 4'd0, 16'd0, 4'd0, 1'b1, n);
        issue(C_WRITEB, 4'd0, 16'd9, 4'd0, 1'b1, n);
        get_strobe(n, lat);
        checks++;
        if (lat !== 3 || line_out !== e || replace_c !== 1'b0 || fma_valid !== 1'b0) begin
            errors++;
            $display("FAIL oor_loadi lat=%0d got=%h rc=%b fv=%b exp lat=3 %h rc=0 fv=0",
                     lat, line_out, replace_c, fma_valid, e);
        end
    endtask

    task automatic test_forwarding();
        int n, lat;
        logic [LW-1:0] e;
        e = '0;
        e[0 +: W] = 16'h1234;
        e[4*W +: W] = 16'h5555;
        e[8*W +: W] = 16'hBEEF;
        issue(C_LOADI, 4'd4, 16'h5555, 4'd0, 1'b1, n);
        issue(C_SMA, 4'd0, 16'hF007, 4'd0, 1'b1, n);
        issue(C_SENDL, 4'd0, 16'd0, 4'd0, 1'b1, n);
        issue(C_WRITEB, 4'd1, 16'h0007, 4'd0, 1'b1, n);
        get_strobe(n, lat);
        checks++;
        if (lat !== 3 || line_out !== e || replace_c !== 1'b1 || fma_valid !== 1'b0) begin
            errors++;
            $display("FAIL fwd_line lat=%0d got=%h rc=%b fv=%b exp lat=3 %h rc=1 fv=0",
                     lat, line_out, replace_c, fma_valid, e);
        end
    endtask

    task automatic test_back_to_back();
        int n, n1, cnt;
        int lat_a [3];
        logic [W-1:0] w1_a [3];
        logic [1:0] sb_a [3];
        logic [1:0] sb_e [3];
        sb_e[0] = 2'b00;
        sb_e[1] = 2'b10;
        sb_e[2] = 2'b01;
        for (int i = 1; i <= 3; i++) begin
            issue(C_LOADI, 4'd1, 16'h0100 + 16'(i), 4'd0, 1'b1, n);
            issue(C_SMA, 4'd0, 16'(i), 4'd0, 1'b1, n);
            issue(C_SENDL, 4'd0, 16'd0, 4'd0, 1'b1, n);
        end
        issue(C_WRITEB, 4'd0, 16'd1, 4'd0, 1'b1, n1);
        issue(C_WRITEB, 4'd1, 16'd2, 4'd0, 1'b1, n);
        issue(C_WRITEB, 4'd0, 16'd3, 4'd1, 1'b1, n);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (line_valid === 1'b1 && cnt < 3) begin
                lat_a[cnt] = cyc - n1;
                w1_a[cnt] = line_out[W +: W];
                sb_a[cnt] = {replace_c, fma_valid};
                cnt++;
            end
        end
        checks++;
        if (cnt != 3) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=3", cnt);
        end
        for (int i = 0; i < cnt; i++) begin
            checks++;
            if (lat_a[i] != 3 + i || w1_a[i] !== 16'h0101 + 16'(i) || sb_a[i] !== sb_e[i]) begin
                errors++;
                $display("FAIL b2b_%0d lat=%0d w1=%h sb=%b exp lat=%0d w1=%h sb=%b", i,
                         lat_a[i], w1_a[i], sb_a[i], 3 + i, 16'h0101 + 16'(i), sb_e[i]);
            end
        end
    endtask

    task automatic test_ignored();
        int n, lat;
        issue(C_LOADI, 4'd2, 16'h7777, 4'd0, 1'b1, n);
        issue(C_NOP, 4'd2, 16'hAAAA, 4'd1, 1'b1, n);
        issue(C_LOADB, 4'd2, 16'hAAAA, 4'd1, 1'b1, n);
        issue(C_ADDI, 4'd2, 16'hAAAA, 4'd1, 1'b1, n);
        issue(C_SMA, 4'd0, 16'd20, 4'd0, 1'b0, n);
        issue(C_LOADI, 4'd1, 16'hFFFF, 4'd0, 1'b0, n);
        issue(C_SENDL, 4'd0, 16'd0, 4'd0, 1'b0, n);
        issue(C_WRITEB, 4'd1, 16'd3, 4'd1, 1'b0, n);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (line_valid !== 1'b0 || addr_o !== 12'd3) begin
                errors++;
                $display("FAIL ign_idle cyc=%0d v=%b addr=%h exp v=0 addr=003", cyc, line_valid, addr_o);
            end
        end
        issue(C_WRITEB, 4'd0, 16'd3, 4'd0, 1'b1, n);
        get_strobe(n, lat);
        checks++;
        if (lat !== 3 || line_out[W +: W] !== 16'h0103 || line_out[2*W +: W] !== 16'h0000) begin
            errors++;
            $display("FAIL ign_cache lat=%0d w1=%h w2=%h exp lat=3 w1=0103 w2=0000",
                     lat, line_out[W +: W], line_out[2*W +: W]);
        end
        issue(C_SENDL, 4'd0, 16'd0, 4'd0, 1'b1, n);
        issue(C_WRITEB, 4'd0, 16'd3, 4'd0, 1'b1, n);
        get_strobe(n, lat);
        checks++;
        if (lat !== 3 || line_out[W +: W] !== 16'h0103 || line_out[2*W +: W] !== 16'h7777) begin
            errors++;
            $display("FAIL ign_buf lat=%0d w1=%h w2=%h exp lat=3 w1=0103 w2=7777",
                     lat, line_out[W +: W], line_out[2*W +: W]);
        end
    endtask

    task automatic test_random();
        int n, sel, wait_cnt;
        logic [3:0] op, ra, rb;
        logic [15:0] imm;
        for (int i = 0; i < 32; i++) begin
            issue(C_SMA, 4'd0, 16'(i), 4'd0, 1'b1, n);
            issue(C_SENDL, 4'd0, 16'd0, 4'd0, 1'b1, n);
        end
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0:       op = C_SMA;
                1, 2:    op = C_LOADI;
                3:       op = C_SENDL;
                4, 5, 6: op = C_WRITEB;
                7:       op = C_LOADB;
                8:       op = C_NOP;
                default: op = 4'($urandom_range(0, 15));
            endcase
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            imm = 16'($urandom_range(0, 65535));
            if (op == C_SMA || op == C_WRITEB) imm[11:5] = '0;
            issue(op, ra, imm, rb, ($urandom_range(0, 9) < 8), n);
        end
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_drain pending=%0d exp=0", exp_q.size());
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_round_trip();
        test_out_of_range();
        test_forwarding();
        test_back_to_back();
        test_ignored();
        test_random();
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout cyc=%0d exp finish before limit", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_cache_controller.md
# data_cache_controller

Memory-side consumer of the instruction controller's output. Takes each instruction strobed with the memory-valid flag, executes the memory opcodes SMA, LOADI, SENDL and WRITEB against a working line buffer and the on-chip data cache BRAM, and streams cache lines to the FMA block array with their per-line control bits. Sits directly downstream of the controller and upstream of the FMA blocks.

## Interface
- `INSTRUCTION_WIDTH`, 32: instruction bits; bit 0 is the MSB; fields `[0:3]` op, `[4:7]` reg_a, `[8:23]` imm, `[24:27]` reg_b.
- `DATA_CACHE_WIDTH`, 16: bits per fixed-point word.
- `DATA_CACHE_DEPTH`, 4096: lines in the data cache.
- `WORDS_PER_LINE`, 9: words per line (3 FMAs × a, b, c); must be ≤16.
- `INIT_FILE`, "": cache init file; empty means zeroed.

Ports:
- `clk_in`  in  1  sole clock.
- `rst_in`  in  1  asynchronous, active-low reset.
- `instr_in`  in  INSTRUCTION_WIDTH  instruction from the controller.
- `instr_valid_in`  in  1  one-cycle strobe; exactly one instruction per high cycle.
- `line_out`  out  WORDS_PER_LINE*DATA_CACHE_WIDTH  line to the FMAs; word k at bits `[k*W +: W]`.
- `replace_c_out`  out  1  LSB of the WRITEB reg_a field (`instr[7]`).
- `fma_valid_out`  out  1  LSB of the WRITEB reg_b field (`instr[27]`).
- `line_valid_out`  out  1  one-cycle strobe qualifying the three outputs above.
- `addr_out`  out  clog2(DATA_CACHE_DEPTH)  current memory address register (debug).

## Operation
- Opcodes come from the shared package: NOP 0000, SMA 0110, LOADI 0111, SENDL 1000, LOADB 1001, WRITEB 1010.
- An instruction acts only on a cycle where `instr_valid_in` is high. Other opcodes, including NOP and LOADB, have no effect. LOADB belongs to the FMA writeback path.
- **SMA:** `addr` ← imm, truncated to clog2(DEPTH) LSBs.
- **LOADI:** `line_buf[reg_a]` ← imm[15:0], sized to DATA_CACHE_WIDTH (truncate or zero-extend). If reg_a ≥ WORDS_PER_LINE, nothing changes.
- **SENDL:** cache[`addr`] ← `line_buf`, committed at the sampling edge (BRAM port A, write enable driven combinationally from the strobe). `line_buf` is unchanged.
- **WRITEB:** read cache[imm truncated] on port B. `replace_c` and `fma_valid` bits travel in a 3-stage sideband shift register alongside a valid bit. When the data emerges, register it onto `line_out` and pulse `line_valid_out`. The sideband outputs are updated together with `line_out`.
- Outputs hold their last values between strobes. Only `line_valid_out` returns to 0.
- **Pipeline:** WRITEB is fully pipelined at one per cycle, with no backpressure and no `ready`.

## Timing
- Reset (`rst_in` low, async): `addr`=0, `line_buf` all 0, `line_out`=0, `replace_c_out`=0, `fma_valid_out`=0, `line_valid_out`=0, sideband pipe cleared.
- A WRITEB in flight when reset asserts is dropped and produces no strobe. Cache contents are not reset.
- **LOADI / SMA:** visible at the edge that samples the strobe; a following instruction one cycle later sees the new value.
- **SENDL:** the write lands at edge N (the sampling edge). A WRITEB to the same line sampled at N+1 or later returns the new data.
- **WRITEB sampled at edge N:** `line_valid_out` is high during the cycle after edge N+3, for exactly one cycle. Latency is 3 (2 BRAM + 1 output register).
- **Back-to-back WRITEBs** at N and N+1 give strobes at N+3 and N+4, in order, each with its own sideband bits.
- **SENDL and WRITEB to the same line in consecutive cycles:** the read-first port-B read of a line written by SENDL at the same edge is not possible, because the instruction stream is serial.

## Structure
- Package `gpu_isa_pkg` holds:
  - the opcode enum shared with the controller;
  - field slice constants (OP, REG_A, IMM, REG_B);
  - the NOP/memory-opcode predicate function.
- Sub-module `data_cache`: wrapper around the team's true-dual-port read-first 2-clock BRAM, with port A write-only and port B read-only, HIGH_PERFORMANCE. Its reset is driven from `!rst_in`, synchronised.
- Everything else (address register, line buffer, sideband pipe, output register) lives in this module.

## Test plan
- **Reset:** assert `rst_in`=0 mid-WRITEB → all outputs 0, no `line_valid_out` afterwards, `addr_out`=0.
- **Round trip:**
  - Stimulus: SMA 5; LOADI w0=0x1234, w8=0xBEEF; SENDL; WRITEB imm=5 with reg_a=1, reg_b=1.
  - Required response: 3 cycles later `line_out` word0=0x1234, word8=0xBEEF, others 0; `replace_c_out`=1; `fma_valid_out`=1; one-cycle strobe.
- **Out-of-range LOADI:** LOADI reg_a=12 → `line_buf` unchanged; verified via SENDL/WRITEB readback.
- **Forwarding:** SENDL to line 7 immediately followed by WRITEB 7 → new data returned.
- **Throughput:** WRITEB to lines 1, 2, 3 on consecutive strobes, with sidebands (0,0), (1,0), (0,1) → three consecutive strobes with matching data and sidebands.
- **Ignored opcodes:** NOP, LOADB, ADDI, and any opcode with `instr_valid_in`=0 → no state change, no strobe.
